// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a result accumulator and a
// valid/ready handshake on both sides.
//
// Stage 1 registers the operation (A, B, opcode, use_acc).
// Stage 2 computes the result and flags and holds them for the consumer.
// The accumulator is loaded with every legal result that enters stage 2.
// Because the operand-A mux sits in stage 2, an op that selects the
// accumulator always sees the result of the op directly ahead of it.
// Therefore no forwarding path is needed.
//
// Ports
//   i_clk, i_reset    clock, asynchronous active-high reset
//   i_valid, o_ready  upstream handshake (operation accepted on i_valid & o_ready)
//   i_a, i_b          signed operands; i_b[SHW-1:0] is the shift amount
//   i_opcode          operation select
//   i_use_acc         replace operand A with the accumulator
//   o_valid, i_ready  downstream handshake (result consumed on o_valid & i_ready)
//   o_res             result
//   o_carry, o_ovf, o_zero, o_neg, o_err   result flags
module alu_pipe #(
    parameter int SIZE = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    input  logic [5:0]      i_opcode,
    input  logic            i_use_acc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [SIZE-1:0] o_res,
    output logic            o_carry,
    output logic            o_ovf,
    output logic            o_zero,
    output logic            o_neg,
    output logic            o_err
);
    localparam int SHW = $clog2(SIZE);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SLL = 6'b000000;

    // Stage 1
    logic            s1_valid_q;
    logic [SIZE-1:0] s1_a_q;
    logic [SIZE-1:0] s1_b_q;
    logic [5:0]      s1_op_q;
    logic            s1_use_acc_q;

    // Stage 2 / outputs
    logic            s2_valid_q;
    logic [SIZE-1:0] res_q;
    logic            carry_q, ovf_q, zero_q, neg_q, err_q;
    logic [SIZE-1:0] acc_q;

    // Stage 2 next-state
    logic [SIZE-1:0] res_d;
    logic            carry_d, ovf_d, zero_d, neg_d, err_d;

    logic [SIZE-1:0] a_eff;
    logic [SIZE:0]   sum_w;
    logic [SIZE:0]   diff_w;
    logic [SHW-1:0]  shamt;
    logic            stall;
    logic            advance;

    // The held result blocks the whole pipe; everything moves together otherwise.
    assign stall   = s2_valid_q & ~i_ready;
    assign advance = ~stall;
    assign o_ready = advance;

    assign a_eff  = s1_use_acc_q ? acc_q : s1_a_q;
    assign sum_w  = {1'b0, a_eff} + {1'b0, s1_b_q};
    // The top bit of the extended difference is the unsigned borrow.
    assign diff_w = {1'b0, a_eff} - {1'b0, s1_b_q};
    assign shamt  = s1_b_q[SHW-1:0];

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                res_d   = sum_w[SIZE-1:0];
                carry_d = sum_w[SIZE];
                ovf_d   = (a_eff[SIZE-1] == s1_b_q[SIZE-1]) &&
                          (sum_w[SIZE-1] != a_eff[SIZE-1]);
            end
            OP_SUB: begin
                res_d   = diff_w[SIZE-1:0];
                carry_d = diff_w[SIZE];
                ovf_d   = (a_eff[SIZE-1] != s1_b_q[SIZE-1]) &&
                          (diff_w[SIZE-1] != a_eff[SIZE-1]);
            end
            OP_AND:  res_d = a_eff & s1_b_q;
            OP_OR:   res_d = a_eff | s1_b_q;
            OP_XOR:  res_d = a_eff ^ s1_b_q;
            OP_NOR:  res_d = ~(a_eff | s1_b_q);
            OP_SRL:  res_d = a_eff >> shamt;
            OP_SRA:  res_d = $unsigned($signed(a_eff) >>> shamt);
            OP_SLL:  res_d = a_eff << shamt;
            default: err_d = 1'b1;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[SIZE-1];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_use_acc_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_a_q       <= i_a;
                s1_b_q       <= i_b;
                s1_op_q      <= i_opcode;
                s1_use_acc_q <= i_use_acc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            acc_q      <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            // Bubbles leave the previous result and the accumulator in place.
            if (s1_valid_q) begin
                res_q   <= res_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
                neg_q   <= neg_d;
                err_q   <= err_d;
                if (!err_d) begin
                    acc_q <= res_d;
                end
            end
        end
    end

    assign o_valid = s2_valid_q;
    assign o_res   = res_q;
    assign o_carry = carry_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;
    assign o_neg   = neg_q;
    assign o_err   = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (SIZE=8): directed vectors with literal expectations
// plus an arithmetic reference model and a per-cycle output compare process.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_a = '0;
    logic [7:0] i_b = '0;
    logic [5:0] i_opcode = '0;
    logic       i_use_acc = 1'b0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_res;
    logic       o_carry, o_ovf, o_zero, o_neg, o_err;

    alu_pipe #(.SIZE(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_opcode(i_opcode), .i_use_acc(i_use_acc),
        .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res),
        .o_carry(o_carry), .o_ovf(o_ovf), .o_zero(o_zero), .o_neg(o_neg),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100,
                           OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111,
                           SRL = 6'b000010, SRA = 6'b000011, SLL = 6'b000000;

    typedef struct {
        logic [7:0] res;
        logic [4:0] flags;   // {carry, ovf, zero, neg, err}
        bit         has_lit;
        logic [7:0] lit_res;
        logic [4:0] lit_flags;
        int         id;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         pushed = 0;
    int         got = 0;
    int         dropped = 0;
    int         cyc = 0;
    logic [7:0] model_acc = '0;
    logic [7:0] last_res = '0;
    bit         lit_v = 0;
    logic [7:0] lit_r = '0;
    logic [4:0] lit_f = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic exp_t model(input logic [5:0] op, input int a, input int b);
        exp_t e;
        int sa, sb, r, sr, n;
        bit c, o, err;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        n  = b % 8;
        c = 0; o = 0; err = 0; r = 0;
        case (op)
            ADD:  begin r = a + b; c = (r > 255); sr = sa + sb; o = (sr > 127) || (sr < -128); end
            SUB:  begin r = a - b; c = (a < b);   sr = sa - sb; o = (sr > 127) || (sr < -128); end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            NOR_: r = 255 - (a | b);
            SRL:  r = a >> n;
            SLL:  r = a << n;
            SRA:  r = sa >>> n;
            default: err = 1;
        endcase
        r = r & 255;
        e.res   = 8'(r);
        e.flags = {c, o, (r == 0), (r >= 128), err};
        e.has_lit = 0; e.lit_res = '0; e.lit_flags = '0; e.id = 0;
        return e;
    endfunction

    // Per-cycle compare and model update, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_o_valid", o_valid, 0);
            check("rst_o_ready", o_ready, 1);
        end else begin
            check("o_ready_vs_stall", o_ready, !(o_valid && !i_ready));
            if (o_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_result actual=%0h required=none", o_res);
                end else begin
                    e = q[0];
                    check("res", o_res, e.res);
                    check("flags", {o_carry, o_ovf, o_zero, o_neg, o_err}, e.flags);
                    if (e.has_lit) begin
                        check("lit_res", o_res, e.lit_res);
                        check("lit_flags", {o_carry, o_ovf, o_zero, o_neg, o_err}, e.lit_flags);
                        check("model_vs_lit", {e.res, e.flags}, {e.lit_res, e.lit_flags});
                    end
                    if (i_ready) begin
                        $display("result id=%0d res=%02h flags(c,o,z,n,e)=%05b", e.id, o_res,
                                 {o_carry, o_ovf, o_zero, o_neg, o_err});
                        void'(q.pop_front());
                        last_res = e.res;
                        got++;
                    end
                end
            end else begin
                check("idle_res_held", o_res, last_res);
            end
            if (i_valid && o_ready) begin
                e = model(i_opcode, int'(i_use_acc ? model_acc : i_a), int'(i_b));
                e.has_lit = lit_v; e.lit_res = lit_r; e.lit_flags = lit_f; e.id = pushed;
                if (!e.flags[0]) model_acc = e.res;
                q.push_back(e);
                pushed++;
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit ua, input bit hl, input logic [7:0] lr, input logic [4:0] lf);
        int n;
        i_opcode = op; i_a = a; i_b = b; i_use_acc = ua;
        lit_v = hl; lit_r = lr; lit_f = lf;
        i_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_ready) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL issue_timeout actual=stalled required=accepted");
                break;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int c0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_valid", o_valid, 0);
        check("reset_ready", o_ready, 1);
        check("reset_res", o_res, 0);
        check("reset_flags", {o_carry, o_ovf, o_zero, o_neg, o_err}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Arithmetic, logic and shift vectors with hand-computed results.
        issue(ADD, 8'h7F, 8'h01, 0, 1, 8'h80, 5'b01010);
        issue(ADD, 8'hFF, 8'h01, 0, 1, 8'h00, 5'b10100);
        issue(SUB, 8'h03, 8'h05, 0, 1, 8'hFE, 5'b10010);
        issue(SRA, 8'h80, 8'h03, 0, 1, 8'hF0, 5'b00010);
        issue(SRL, 8'h80, 8'h03, 0, 1, 8'h10, 5'b00000);
        issue(SLL, 8'h01, 8'h07, 0, 1, 8'h80, 5'b00010);
        issue(SLL, 8'h01, 8'h09, 0, 1, 8'h02, 5'b00000);
        issue(SRA, 8'h40, 8'h06, 0, 1, 8'h01, 5'b00000);
        issue(AND_, 8'hF0, 8'h3C, 0, 1, 8'h30, 5'b00000);
        issue(OR_, 8'hF0, 8'h0F, 0, 1, 8'hFF, 5'b00010);
        issue(XOR_, 8'hAA, 8'hAA, 0, 1, 8'h00, 5'b00100);
        issue(NOR_, 8'h00, 8'h00, 0, 1, 8'hFF, 5'b00010);
        issue(SUB, 8'h80, 8'h01, 0, 1, 8'h7F, 5'b01000);

        // Accumulator chain, back to back.
        issue(ADD, 8'h05, 8'h03, 0, 1, 8'h08, 5'b00000);
        issue(ADD, 8'h77, 8'h02, 1, 1, 8'h0A, 5'b00000);
        issue(SUB, 8'h55, 8'h0A, 1, 1, 8'h00, 5'b00100);

        // Illegal opcodes leave the accumulator alone.
        issue(ADD, 8'h20, 8'h10, 0, 1, 8'h30, 5'b00000);
        issue(6'b111111, 8'h01, 8'h01, 0, 1, 8'h00, 5'b00101);
        issue(6'b010101, 8'h07, 8'h07, 1, 1, 8'h00, 5'b00101);
        issue(ADD, 8'hEE, 8'h01, 1, 1, 8'h31, 5'b00000);
        drain();

        // Bubbles: outputs idle with result held.
        repeat (3) @(posedge clk);
        #1;

        // Downstream stall for 4 cycles with 3 ops offered.
        fork
            begin
                i_ready = 1'b0;
                @(posedge clk); @(posedge clk);
                @(negedge clk);
                check("stall_ready_low", o_ready, 0);
                check("stall_res_held", o_res, 8'h02);
                @(negedge clk);
                check("stall_ready_low2", o_ready, 0);
                check("stall_res_held2", o_res, 8'h02);
                @(posedge clk); @(posedge clk);
                #1 i_ready = 1'b1;
            end
            begin
                issue(ADD, 8'h01, 8'h01, 0, 1, 8'h02, 5'b00000);
                issue(ADD, 8'h02, 8'h02, 0, 1, 8'h04, 5'b00000);
                issue(ADD, 8'h99, 8'h04, 1, 1, 8'h08, 5'b00000);
            end
        join
        drain();

        // Sustained throughput: six ops in six cycles.
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            issue(ADD, 8'(k * 16), 8'(k + 1), 0, 0, '0, '0);
        end
        check("throughput_cycles", cyc - c0, 6);
        drain();

        // Reset with two ops in flight.
        i_ready = 1'b0;
        issue(ADD, 8'h09, 8'h09, 0, 0, '0, '0);
        issue(ADD, 8'h11, 8'h01, 0, 0, '0, '0);
        check("inflight_valid", o_valid, 1);
        #2 rst = 1'b1;
        dropped += q.size();
        q.delete();
        model_acc = '0;
        last_res = '0;
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_res", o_res, 0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        i_ready = 1'b1;
        // First edge after release accepts; accumulator must be cleared.
        issue(ADD, 8'hC3, 8'h05, 1, 1, 8'h05, 5'b00000);
        repeat (4) @(posedge clk);
        #1;
        drain();

        check("result_count", got, pushed - dropped);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
